// File: rtl/gpc231_4_reg.sv
// Registered (2,3,1;4) generalized parallel counter.
// Compresses 1x w1, 3x w2 and 2x w4 bits into a 4-bit sum with one cycle of latency.
module gpc231_4_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       src0,
  input  logic [2:0] src1,
  input  logic [1:0] src2,
  output logic       out_valid,
  output logic [3:0] dst
);

  localparam int unsigned DST_W = 4;

  logic             col1_sum;
  logic             col1_carry;
  logic             col2_sum;
  logic             col2_carry;
  logic [DST_W-1:0] sum;

  logic [DST_W-1:0] dst_d, dst_q;
  logic             out_valid_d, out_valid_q;

  // Column 1 full adder; its carry has weight 4 and joins column 2.
  always_comb begin
    col1_sum   = src1[0] ^ src1[1] ^ src1[2];
    col1_carry = (src1[0] & src1[1]) | (src1[0] & src1[2]) | (src1[1] & src1[2]);
  end

  // Column 2 full adder over src2 and the column-1 carry; its carry ripples into dst[3].
  always_comb begin
    col2_sum   = src2[0] ^ src2[1] ^ col1_carry;
    col2_carry = (src2[0] & src2[1]) | (src2[0] & col1_carry) | (src2[1] & col1_carry);
    sum        = {col2_carry, col2_sum, col1_sum, src0};
  end

  always_comb begin
    dst_d       = dst_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      dst_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q       <= DST_W'(0);
      out_valid_q <= 1'b0;
    end else begin
      dst_q       <= dst_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dst       = dst_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gpc231_4_reg.sv
// Self-checking bench for gpc231_4_reg against a popcount-based reference model.
module tb_gpc231_4_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       src0;
  logic [2:0] src1;
  logic [1:0] src2;
  logic       out_valid;
  logic [3:0] dst;

  int unsigned n_cmp;
  int unsigned n_err;

  // Reference state: what the outputs should show after the latest edge.
  int unsigned exp_dst;
  int unsigned exp_valid;

  gpc231_4_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .src0      (src0),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .dst       (dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pattern bit order: {src2[1], src2[0], src1[2], src1[1], src1[0], src0}.
  function automatic int unsigned ref_sum(input logic [5:0] p);
    int unsigned w1, w2, w4;
    w1 = 32'(p[0]);
    w2 = 32'(p[1]) + 32'(p[2]) + 32'(p[3]);
    w4 = 32'(p[4]) + 32'(p[5]);
    return w1 + 2 * w2 + 4 * w4;
  endfunction

  task automatic set_inputs(input logic v, input logic [5:0] p);
    in_valid = v;
    src0     = p[0];
    src1     = p[3:1];
    src2     = p[5:4];
  endtask

  // Drive one cycle, clock it, update the model and compare outputs just after the edge.
  task automatic step(input string tag, input logic v, input logic [5:0] p);
    set_inputs(v, p);
    @(posedge clk);
    #1;
    if (v) exp_dst = ref_sum(p);
    exp_valid = 32'(v);
    check({tag, ".dst"}, 32'(dst), exp_dst);
    check({tag, ".valid"}, 32'(out_valid), exp_valid);
  endtask

  initial begin
    logic [5:0] pat;
    logic       v;
    n_cmp     = 0;
    n_err     = 0;
    exp_dst   = 0;
    exp_valid = 0;
    rst_n     = 1'b0;
    set_inputs(1'b1, 6'h3F);

    // Power-up reset: outputs held at zero even while clocks arrive with valid input.
    #2;
    check("por.dst", 32'(dst), 0);
    check("por.valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    check("por_clk.dst", 32'(dst), 0);
    check("por_clk.valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_inputs(1'b0, 6'h00);
    #1;

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 64; i++) begin
      pat = 6'(i);
      step($sformatf("exh%0d", i), 1'b1, pat);
    end

    // Corners.
    step("corner_a", 1'b1, {2'b11, 3'b000, 1'b1});
    step("corner_b", 1'b1, {2'b00, 3'b111, 1'b0});
    step("corner_c", 1'b1, {2'b10, 3'b101, 1'b1});

    // Hold: capture full sum, then idle with changed inputs.
    step("hold_cap", 1'b1, 6'h3F);
    for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i), 1'b0, 6'h00);

    // Mid-stream asynchronous reset between edges.
    step("rst_pre", 1'b1, 6'h3F);
    @(negedge clk);
    set_inputs(1'b1, 6'h2A);
    #2;
    rst_n = 1'b0;
    #1;
    exp_dst   = 0;
    exp_valid = 0;
    check("rst_async.dst", 32'(dst), exp_dst);
    check("rst_async.valid", 32'(out_valid), exp_valid);
    @(posedge clk);
    #1;
    check("rst_held.dst", 32'(dst), exp_dst);
    check("rst_held.valid", 32'(out_valid), exp_valid);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_release", 1'b1, 6'h15);

    // Streaming alternation.
    for (int i = 0; i < 8; i++) step($sformatf("stream%0d", i), 1'b1, (i % 2 == 0) ? 6'h2A : 6'h15);

    // Random traffic with random valid gaps.
    for (int i = 0; i < 300; i++) begin
      v   = 1'($urandom_range(0, 3) != 0);
      pat = 6'($urandom);
      step($sformatf("rnd%0d", i), v, pat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
